// File: rtl/sorted_search_pkg.sv
// sorted_search shared types and constants.
// Sizes, FSM states and binary-search step bounds.
package sorted_search_pkg;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int N  = 1 << AW;

  typedef enum logic [2:0] {
    CAPTURE,
    CHECK,
    READY,
    SEARCH,
    RESP
  } state_t;

  localparam logic [AW-1:0] STEP_FIRST = AW'(N / 2);
  localparam logic [AW-1:0] STEP_LAST  = AW'(1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(N - 1);

endpackage

// File: rtl/sorted_search_mem.sv
// Register file for the captured list.
// One synchronous write port, two combinational read ports.
import sorted_search_pkg::*;

module sorted_search_mem (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra_a,
  input  logic [AW-1:0] ra_b,
  output logic [DW-1:0] rd_a,
  output logic [DW-1:0] rd_b
);

  logic [DW-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];

endmodule

// File: rtl/sorted_search.sv
// Captures the sorter's result list, checks it,
// then serves fixed-latency lower-bound queries.
import sorted_search_pkg::*;

module sorted_search (
  input  logic          clk,
  input  logic          reset,
  input  logic          IRAM_valid,
  input  logic [AW-1:0] IRAM_A,
  input  logic [DW-1:0] IRAM_D,
  input  logic          sort_done,
  input  logic          q_valid,
  input  logic [DW-1:0] q_key,
  output logic          q_ready,
  output logic          r_valid,
  output logic          r_found,
  output logic [AW-1:0] r_index,
  output logic          list_ready,
  output logic          order_err
);

  state_t        state;
  logic [N-1:0]  written;
  logic [AW-1:0] idx;
  logic [AW-1:0] pos;
  logic [AW-1:0] step;
  logic [DW-1:0] key;
  logic [AW-1:0] ra_a;
  logic [AW-1:0] ra_b;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic          we;

  // Port a: probe or left neighbour; port b: mem[pos] or right neighbour
  assign we   = IRAM_valid && (state == CAPTURE);
  assign ra_a = (state == SEARCH) ? pos + step - 1'b1 : idx;
  assign ra_b = (state == RESP) ? pos : idx + 1'b1;

  sorted_search_mem u_mem (
    .clk  (clk),
    .we   (we),
    .wa   (IRAM_A),
    .wd   (IRAM_D),
    .ra_a (ra_a),
    .ra_b (ra_b),
    .rd_a (rd_a),
    .rd_b (rd_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CAPTURE;
      written    <= '0;
      idx        <= '0;
      pos        <= '0;
      step       <= '0;
      key        <= '0;
      q_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_found    <= 1'b0;
      r_index    <= '0;
      list_ready <= 1'b0;
      order_err  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (state)
        CAPTURE: begin
          if (IRAM_valid) written[IRAM_A] <= 1'b1;
          if (sort_done) begin
            idx   <= '0;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (idx != IDX_LAST) begin
            if (rd_a > rd_b) order_err <= 1'b1;
            idx <= idx + 1'b1;
          end else begin
            if (!(&written)) order_err <= 1'b1;
            list_ready <= 1'b1;
            q_ready    <= 1'b1;
            state      <= READY;
          end
        end
        READY: begin
          if (q_valid) begin
            key     <= q_key;
            pos     <= '0;
            step    <= STEP_FIRST;
            q_ready <= 1'b0;
            state   <= SEARCH;
          end
        end
        SEARCH: begin
          if (rd_a < key) pos <= pos + step;
          step <= step >> 1;
          if (step == STEP_LAST) state <= RESP;
        end
        RESP: begin
          r_index <= pos;
          r_found <= (rd_b == key);
          r_valid <= 1'b1;
          q_ready <= 1'b1;
          state   <= READY;
        end
        default: state <= CAPTURE;
      endcase
    end
  end

endmodule

// File: tb/tb_sorted_search.sv
// Self-checking bench for sorted_search.
// Scoreboard on accepts, table vectors, hand sequences.
import sorted_search_pkg::*;

module tb_sorted_search;

  logic          clk = 1'b0;
  logic          reset;
  logic          IRAM_valid;
  logic [AW-1:0] IRAM_A;
  logic [DW-1:0] IRAM_D;
  logic          sort_done;
  logic          q_valid;
  logic [DW-1:0] q_key;
  logic          q_ready;
  logic          r_valid;
  logic          r_found;
  logic [AW-1:0] r_index;
  logic          list_ready;
  logic          order_err;

  sorted_search dut (
    .clk        (clk),
    .reset      (reset),
    .IRAM_valid (IRAM_valid),
    .IRAM_A     (IRAM_A),
    .IRAM_D     (IRAM_D),
    .sort_done  (sort_done),
    .q_valid    (q_valid),
    .q_key      (q_key),
    .q_ready    (q_ready),
    .r_valid    (r_valid),
    .r_found    (r_found),
    .r_index    (r_index),
    .list_ready (list_ready),
    .order_err  (order_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          found;
    logic [AW-1:0] idx;
    int            due;
    bit            dc;
  } exp_t;

  typedef struct {
    logic [DW-1:0] key;
    logic          found;
    logic [AW-1:0] idx;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_acc = 0;
  bit            bad_list = 1'b0;
  exp_t          sb[$];
  exp_t          e;
  logic [DW-1:0] model [N];
  logic [DW-1:0] img [N];
  vec_t          vt [5];

  always @(posedge clk) cyc++;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Linear-scan lower bound over the bench's copy of the list
  function automatic exp_t predict(input logic [DW-1:0] k);
    exp_t p;
    p.idx = AW'(N - 1);
    for (int i = N - 1; i >= 0; i--)
      if (model[i] >= k) p.idx = AW'(i);
    p.found = (model[p.idx] == k);
    p.due = cyc + 6;
    p.dc = bad_list;
    return p;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (q_valid && q_ready) begin
        sb.push_back(predict(q_key));
        n_acc++;
      end
      if (r_valid) begin
        if (sb.size() == 0) begin
          check("r_valid_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("r_latency", cyc, e.due);
          check("r_ready_again", q_ready, 1);
          if (!e.dc) begin
            check("r_found", r_found, e.found);
            check("r_index", r_index, e.idx);
          end
        end
      end else if (sb.size() > 0 && cyc > sb[0].due) begin
        check("r_timeout", cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    IRAM_valid = 1'b0;
    sort_done = 1'b0;
    q_valid = 1'b0;
    tick();
    sb.delete();
    reset = 1'b0;
  endtask

  // Streams img highest address first; sort_done rides the last write
  task automatic capture(input logic [N-1:0] wmask);
    bad_list = (wmask != '1);
    for (int i = 0; i < N - 1; i++)
      if (img[i] > img[i+1]) bad_list = 1'b1;
    for (int a = N - 1; a >= 0; a--) begin
      IRAM_valid = wmask[a];
      IRAM_A = AW'(a);
      IRAM_D = img[a];
      sort_done = (a == 0);
      model[a] = img[a];
      tick();
    end
    IRAM_valid = 1'b0;
    sort_done = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 15) check("list_ready_early", list_ready, 0);
    end
    check("list_ready", list_ready, 1);
    check("q_ready_init", q_ready, 1);
    check("order_err", order_err, bad_list);
  endtask

  task automatic query(input logic [DW-1:0] k);
    int t;
    t = 0;
    while (!q_ready && t < 50) begin
      tick();
      t++;
    end
    if (!q_ready) check("q_ready_wait", q_ready, 1);
    q_valid = 1'b1;
    q_key = k;
    tick();
    q_valid = 1'b0;
    check("q_ready_drop", q_ready, 0);
    t = 0;
    while (sb.size() > 0 && t < 20) begin
      tick();
      t++;
    end
  endtask

  task automatic query_vec(input vec_t v);
    query(v.key);
    check("vec_found", r_found, v.found);
    check("vec_index", r_index, v.idx);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) img[i] = DW'(10 * (i + 1));
  endtask

  initial begin
    reset = 1'b1;
    IRAM_valid = 1'b0;
    IRAM_A = '0;
    IRAM_D = '0;
    sort_done = 1'b0;
    q_valid = 1'b0;
    q_key = '0;
    vt[0] = '{8'd70, 1'b1, 4'd6};
    vt[1] = '{8'd75, 1'b0, 4'd7};
    vt[2] = '{8'd5, 1'b0, 4'd0};
    vt[3] = '{8'd200, 1'b0, 4'd15};
    vt[4] = '{8'd160, 1'b1, 4'd15};

    tick();
    do_reset();
    check("rst_q_ready", q_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_found", r_found, 0);
    check("rst_r_index", r_index, 0);
    check("rst_list_ready", list_ready, 0);
    check("rst_order_err", order_err, 0);

    load_ramp();
    capture('1);
    for (int i = 0; i < 5; i++) query_vec(vt[i]);

    // Duplicates
    do_reset();
    for (int i = 0; i < N; i++) img[i] = 8'h33;
    capture('1);
    query_vec('{8'h33, 1'b1, 4'd0});
    do_reset();
    for (int i = 0; i < N; i++) img[i] = DW'(i + 1);
    img[0] = 8'd1;
    img[1] = 8'd2;
    img[2] = 8'd2;
    img[3] = 8'd2;
    capture('1);
    query_vec('{8'd2, 1'b1, 4'd1});

    // Bad lists still answer with normal timing
    do_reset();
    load_ramp();
    img[4] = 8'h90;
    img[5] = 8'h10;
    capture('1);
    query(8'd70);
    do_reset();
    load_ramp();
    capture(16'hFDFF);
    query(8'd100);
    bad_list = 1'b0;

    // Held q_valid: one accept per 6 cycles
    do_reset();
    load_ramp();
    capture('1);
    n_acc = 0;
    q_valid = 1'b1;
    q_key = 8'd70;
    repeat (13) tick();
    q_valid = 1'b0;
    repeat (10) tick();
    check("held_accepts", n_acc, 3);

    // Writes and sort_done after capture must be ignored
    q_valid = 1'b1;
    q_key = 8'd80;
    tick();
    q_valid = 1'b0;
    IRAM_valid = 1'b1;
    IRAM_A = 4'd3;
    IRAM_D = 8'hFF;
    sort_done = 1'b1;
    repeat (8) tick();
    IRAM_valid = 1'b0;
    sort_done = 1'b0;
    query_vec('{8'd40, 1'b1, 4'd3});
    query_vec(vt[0]);
    check("still_ready", list_ready, 1);
    check("still_ok", order_err, 0);

    // Reset during SEARCH step 2 drops the query
    q_valid = 1'b1;
    q_key = 8'd70;
    tick();
    q_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    sb.delete();
    reset = 1'b0;
    check("mid_q_ready", q_ready, 0);
    check("mid_r_valid", r_valid, 0);
    check("mid_r_found", r_found, 0);
    check("mid_r_index", r_index, 0);
    check("mid_list_ready", list_ready, 0);
    check("mid_order_err", order_err, 0);
    for (int n = 0; n < 8; n++) begin
      tick();
      check("mid_no_rvalid", r_valid, 0);
    end
    load_ramp();
    capture('1);
    query_vec(vt[1]);
    query_vec(vt[4]);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sorted_search.md
# sorted_search

Receiver and query server for the sorter's write-only result port. It captures the 16-byte list the sorter streams out (valid/address/data, highest address first), then checks that every entry was written and that the list ascends by address. After that it answers lower-bound lookup queries with a fixed-latency binary search. It sits between the sorter and any downstream consumer of the sorted list.

## Interface
- DW, 8, data width
- AW, 4, address width; N = 2**AW = 16 entries
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- IRAM_valid  in  1  write strobe from sorter
- IRAM_A  in  AW  write address
- IRAM_D  in  DW  write data
- sort_done  in  1  sorter `done` level; end of list
- q_valid  in  1  query request
- q_key  in  DW  search key
- q_ready  out  1  query accepted when q_valid & q_ready
- r_valid  out  1  one-cycle result pulse
- r_found  out  1  mem[r_index] == key
- r_index  out  AW  lowest index with mem[i] >= key (15 if none)
- list_ready  out  1  capture and check complete
- order_err  out  1  list missing an entry or not ascending; valid while list_ready

## Operation
- States: CAPTURE, CHECK, READY, SEARCH, RESP.
- CAPTURE (reset state):
  - IRAM_valid writes mem[IRAM_A] <= IRAM_D and sets written[IRAM_A].
  - A later write to the same address overwrites the entry.
  - sort_done sampled high moves to CHECK; a write in that same cycle is still captured.
- CHECK, counter i = 0..15, one step per cycle:
  - i < 15: if mem[i] > mem[i+1], set order_err.
  - i == 15: if written != all-ones, set order_err; go to READY.
  - Equal neighbours are legal.
- READY:
  - list_ready = 1, q_ready = 1.
  - On accept: latch key, pos <= 0, step <= 8, go to SEARCH.
  - IRAM_valid and sort_done are ignored in READY, SEARCH and RESP. The list is immutable until reset.
- SEARCH, 4 cycles, step = 8, 4, 2, 1:
  - if mem[pos+step-1] < key, then pos <= pos + step.
  - Arithmetic is unsigned; pos fits AW bits; no wrap is possible.
- RESP, 1 cycle:
  - r_index <= pos, r_found <= (mem[pos] == key), r_valid <= 1.
  - Return to READY.
- Duplicates: the result is the lowest matching index.
- Key above all entries: r_index = 15, r_found = 0.
- order_err does not block queries; results are then undefined but still produced with the same timing.

## Timing
- Reset values:
  - All outputs 0: q_ready, r_valid, r_found, r_index, list_ready, order_err.
  - written is cleared; state is CAPTURE.
  - mem contents are don't-care.
- Reset mid-operation, in any state: the next cycle shows reset values. Any in-flight query is dropped with no r_valid.
- sort_done sampled at edge d: CHECK occupies edges d+1..d+16; list_ready and q_ready go high after edge d+16.
- Query accepted at edge k:
  - q_ready is low after edge k.
  - SEARCH steps at edges k+1..k+4; RESP at edge k+5.
  - r_valid is high for exactly the cycle after edge k+5.
  - q_ready is high again in that same cycle, so a back-to-back query can be accepted at edge k+6.
- Throughput: one query per 6 cycles.
- q_valid held high while q_ready = 0 is not accepted; the held request is taken when q_ready returns.
- r_found and r_index hold their last values between pulses.

## Structure
- Package sorted_search_pkg:
  - DW, AW, N
  - state enum {CAPTURE, CHECK, READY, SEARCH, RESP}
  - search step constants
- Sub-module sorted_search_mem:
  - 16×DW register file
  - one synchronous write port
  - two combinational read ports: one for neighbour compare or probe, one for mem[pos] or mem[i+1]
- Top level holds the FSM, counters, written mask and flags.

## Test plan
1. **Ascending capture and hit.** Writes in sorter order, addr 15 down to 0, data = 10·(addr+1). Assert sort_done. Required: list_ready after 16 cycles, order_err = 0. Then query 70: r_valid 5 cycles after accept, r_found = 1, r_index = 6.
2. **Misses and edges**, same list:
   - key 75: found = 0, index = 7.
   - key 5: found = 0, index = 0.
   - key 200: found = 0, index = 15.
   - key 160: found = 1, index = 15.
3. **Duplicates.** All entries 0x33, plus a list {1,2,2,2,5,…}. Key 0x33 gives index 0, found = 1. Key 2 gives index 1.
4. **Bad lists.**
   - mem[4] = 0x90, mem[5] = 0x10: order_err = 1.
   - Correct list but addr 9 never written: order_err = 1.
   - Queries are still answered with the same timing.
5. **Handshake.**
   - q_valid held high across a search: exactly one accept per 6 cycles.
   - Writes and sort_done pulses during READY and SEARCH leave the contents unchanged.
6. **Reset mid-search.** Reset during SEARCH step 2: next cycle all outputs 0 and list_ready = 0, with no r_valid. A fresh capture then works normally.
